// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential multiplier with 7-segment display.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    CONV,
    DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Decimal digits needed to show the largest product (2^width-1)^2.
  function automatic int unsigned ceil_log10_digits(input int unsigned width);
    int unsigned v;
    int unsigned n;
    v = ((32'd1 << width) - 32'd1) * ((32'd1 << width) - 32'd1);
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n++;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/seq_mult_display_seg7.sv
// One active-low 7-segment digit decoder (gfedcba) with blanking input.
module seg7_digit
  import seq_mult_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seq_mult_display.sv
// Shift-add multiplier, double-dabble BCD conversion and blanked 7-segment output.
module seq_mult_display
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(PW + 1);
  localparam logic [7*DIGITS-1:0] SEG_ONES = '1;
  localparam logic [7*DIGITS-1:0] SEG_RST  = (SEG_ONES << 7) | (7*DIGITS)'(SEG_0);

  if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
    $error("seq_mult_display: WIDTH must be in 2..8");
  end
  if (DIGITS < ceil_log10_digits(WIDTH)) begin : g_bad_digits
    $error("seq_mult_display: DIGITS too small for the full-scale product");
  end

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]       mplier_q, mplier_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [PW-1:0]       bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       product_q, product_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;

  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       bcd_shift;
  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg_new;

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  assign bcd_shift = BW'({bcd_adj, bin_q[PW-1]});

  // Scan from the top digit down; a digit blanks while everything above it is zero.
  always_comb begin
    logic higher_zero;
    blank       = '0;
    higher_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      higher_zero = higher_zero & (bcd_shift[4*(DIGITS-1-i) +: 4] == 4'd0);
      blank[DIGITS-1-i] = higher_zero;
    end
    blank[0] = 1'b0;
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    seg7_digit u_seg7 (
      .bcd_i   (bcd_shift[4*i +: 4]),
      .blank_i (blank[i]),
      .seg_o   (seg_new[7*i +: 7])
    );
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    seg_d     = seg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = PW'(b);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MULT;
        end
      end
      MULT: begin
        if (mcand_q[0]) acc_d = acc_q + mplier_q;
        mcand_d  = mcand_q >> 1;
        mplier_d = mplier_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bin_d   = acc_d;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = bcd_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CW'(1);
        // Outputs load on the final shift so they are already valid during DONE.
        if (cnt_q == CW'(PW - 1)) begin
          product_d = acc_q;
          seg_d     = seg_new;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      seg_q     <= SEG_RST;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      seg_q     <= seg_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign seg     = seg_q;

endmodule
